// File: rtl/mult_div_unit_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package mult_div_unit_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ITERS_DEFAULT = WIDTH_DEFAULT;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// Start/done handshake and HI/LO result bus between the control unit and the MDU.
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mdu_twos_comp.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_twos_comp #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] value_i,
    input  logic         neg_i,
    output logic [W-1:0] result_c
);

    always_comb begin
        result_c = neg_i ? ((~value_i) + W'(1)) : value_i;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV: one product/quotient bit per cycle on magnitudes,
// then a single sign-correction cycle before HI/LO are written.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned ITERS = ITERS_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    localparam int unsigned CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] mag_a_c, mag_b_c, quo_c, rem_c;
    logic [ACC_W-1:0] prod_c;
    logic [WIDTH:0]   add_c, shl_c, diff_c;

    mdu_twos_comp #(.W(WIDTH)) u_mag_a (.value_i(bus.a), .neg_i(bus.a[WIDTH-1]), .result_c(mag_a_c));
    mdu_twos_comp #(.W(WIDTH)) u_mag_b (.value_i(bus.b), .neg_i(bus.b[WIDTH-1]), .result_c(mag_b_c));
    mdu_twos_comp #(.W(ACC_W)) u_prod  (.value_i(acc_q), .neg_i(neg_lo_q), .result_c(prod_c));
    mdu_twos_comp #(.W(WIDTH)) u_quo   (.value_i(acc_q[WIDTH-1:0]), .neg_i(neg_lo_q), .result_c(quo_c));
    mdu_twos_comp #(.W(WIDTH)) u_rem   (.value_i(acc_q[ACC_W-1:WIDTH]), .neg_i(neg_hi_q), .result_c(rem_c));

    // MULT: upper half plus multiplicand with carry; DIV: remainder:dividend shifted left, trial subtract.
    assign add_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} + {1'b0, opd_q};
    assign shl_c  = acc_q[ACC_W-1:WIDTH-1];
    assign diff_c = shl_c - {1'b0, opd_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if ((bus.op == OP_DIV) && (bus.b == '0)) begin
                        dz_d = 1'b1;
                    end else begin
                        op_d     = bus.op;
                        neg_lo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        neg_hi_d = bus.a[WIDTH-1];
                        opd_d    = (bus.op == OP_DIV) ? mag_b_c : mag_a_c;
                        acc_d    = {WIDTH'(0), (bus.op == OP_DIV) ? mag_a_c : mag_b_c};
                        cnt_d    = '0;
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (op_q == OP_MULT) begin
                    acc_d = acc_q[0] ? {add_c, acc_q[WIDTH-1:1]} : {1'b0, acc_q[ACC_W-1:1]};
                end else if (!diff_c[WIDTH]) begin
                    acc_d = {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {shl_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                if (op_q == OP_MULT) begin
                    hi_d = prod_c[ACC_W-1:WIDTH];
                    lo_d = prod_c[WIDTH-1:0];
                end else begin
                    hi_d = rem_c;
                    lo_d = quo_c;
                end
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain signed-arithmetic model.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Signed reference: 64-bit arithmetic so -2^31 / -1 does not trap.
    function automatic void model(input logic op_v, input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sa;
        longint sb;
        logic [63:0] p;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        if (op_v == OP_MULT) begin
            p  = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
        end else begin
            q  = 64'(sa / sb);
            r  = 64'(sa % sb);
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    task automatic run_op(input logic op_v, input logic [31:0] av, input logic [31:0] bv, input bit poke);
        logic [31:0] eh;
        logic [31:0] el;
        int k;
        bit busy_drop;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 1'($urandom_range(0, 1));
        bus.a     = $urandom;
        bus.b     = $urandom;
        if (op_v == OP_DIV && bv == 32'd0) begin
            check("dz_pulse", 64'(bus.div_zero), 64'd1);
            check("dz_busy", 64'(bus.busy), 64'd0);
            check("dz_done", 64'(bus.done), 64'd0);
            @(posedge clk);
            #1;
            check("dz_clear", 64'(bus.div_zero), 64'd0);
            check("dz_busy2", 64'(bus.busy), 64'd0);
            check("dz_hi", 64'(bus.hi), 64'(exp_hi));
            check("dz_lo", 64'(bus.lo), 64'(exp_lo));
        end else begin
            check("busy_start", 64'(bus.busy), 64'd1);
            check("no_dz", 64'(bus.div_zero), 64'd0);
            k = 0;
            busy_drop = 1'b0;
            while (k < 100) begin
                @(posedge clk);
                #1;
                k++;
                if (bus.done) break;
                if (!bus.busy || bus.div_zero) busy_drop = 1'b1;
                if (poke && k == 10) begin
                    bus.start = 1'b1;
                    bus.op    = ~op_v;
                    bus.a     = $urandom;
                    bus.b     = $urandom;
                end
                if (poke && k == 11) bus.start = 1'b0;
            end
            bus.start = 1'b0;
            model(op_v, av, bv, eh, el);
            exp_hi = eh;
            exp_lo = el;
            check("latency", 64'(k), 64'd33);
            check("busy_run", 64'(busy_drop), 64'd0);
            check("busy_at_done", 64'(bus.busy), 64'd1);
            check("hi", 64'(bus.hi), 64'(eh));
            check("lo", 64'(bus.lo), 64'(el));
            @(posedge clk);
            #1;
            check("done_one_cycle", 64'(bus.done), 64'd0);
            check("busy_end", 64'(bus.busy), 64'd0);
            check("hi_hold", 64'(bus.hi), 64'(eh));
            check("lo_hold", 64'(bus.lo), 64'(el));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5];
        edges[0] = 32'h0000_0000;
        edges[1] = 32'h0000_0001;
        edges[2] = 32'hFFFF_FFFF;
        edges[3] = 32'h8000_0000;
        edges[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_hi    = '0;
        exp_lo    = '0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_dz", 64'(bus.div_zero), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed corner cases, with literal expectations cross-checking the model.
        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b0);
        check("mul7x-3_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mul7x-3_lo", 64'(bus.lo), 64'hFFFF_FFEB);
        run_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        check("mulmax_hi", 64'(bus.hi), 64'h3FFF_FFFF);
        check("mulmax_lo", 64'(bus.lo), 64'h0000_0001);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        check("mulmin_hi", 64'(bus.hi), 64'h4000_0000);
        check("mulmin_lo", 64'(bus.lo), 64'h0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div-7/2_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div-7/2_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        check("div7/-2_lo", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div7/-2_hi", 64'(bus.hi), 64'h1);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("divovf_lo", 64'(bus.lo), 64'h8000_0000);
        check("divovf_hi", 64'(bus.hi), 64'h0);

        // Divide by zero after a completed op leaves hi/lo non-trivial.
        run_op(OP_MULT, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0);

        // Start re-pulsed during CALC must be ignored.
        run_op(OP_DIV, 32'hFFF0_1234, 32'd77, 1'b1);
        run_op(OP_MULT, 32'h0BAD_F00D, 32'hFFFF_1234, 1'b1);

        // Asynchronous reset mid-CALC aborts and clears outputs at once.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'h7654_3210;
        bus.b     = 32'h0123_4567;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_hi", 64'(bus.hi), 64'd0);
        check("arst_lo", 64'(bus.lo), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op(OP_MULT, 32'd3, 32'd4, 1'b0);
        check("post_rst_lo", 64'(bus.lo), 64'd12);
        check("post_rst_hi", 64'(bus.hi), 64'd0);

        // Randomized mix including edge operands and occasional divide-by-zero.
        for (int i = 0; i < 60; i++) begin
            logic        op_r;
            logic [31:0] a_r;
            logic [31:0] b_r;
            op_r = 1'($urandom_range(0, 1));
            a_r  = pick_operand();
            b_r  = pick_operand();
            run_op(op_r, a_r, b_r, (i % 7) == 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
